// File: rtl/div_restoring_4bit_pkg.sv
// Shared types and constants for the restoring divider.
// Holds the FSM state encoding and the counter-width helper.
package div_pkg;

   localparam int DEF_WIDTH = 4;
   localparam int CNT_W     = $clog2(DEF_WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/div_restoring_4bit_if.sv
// Request/result bundle for the restoring divider.
// The master drives the request; the divider (slave) returns the result.
interface div_restoring_4bit_if
   import div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/div_restoring_4bit_addsub.sv
// Ripple-carry add/sub built from full-adder cells.
// sel=1 subtracts (a + ~b + 1); cout=1 then means no borrow.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module addsub_nbit #(
   parameter int N = 5
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         sel,
   output logic         cout,
   output logic [N-1:0] result
);
   logic [N:0]   carry;
   logic [N-1:0] b_x;

   assign b_x      = b ^ {N{sel}};
   assign carry[0] = sel;

   for (genvar i = 0; i < N; i++) begin : g_fa
      full_adder u_fa (
         .a    (a[i]),
         .b    (b_x[i]),
         .cin  (carry[i]),
         .s    (result[i]),
         .cout (carry[i+1])
      );
   end

   assign cout = carry[N];
endmodule

// File: rtl/div_restoring_4bit.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
//   state | meaning
//   IDLE  | waiting for start; outputs hold the last result
//   RUN   | one shift/trial-subtract iteration per edge, WIDTH iterations
//   DONE  | single-cycle done pulse; results already registered
module div_restoring_4bit
   import div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   div_restoring_4bit_if.slave  bus
);
   localparam int CW = cnt_width(WIDTH);

   state_t           state, state_nxt;
   logic [WIDTH:0]   r_w;
   logic [WIDTH-1:0] q_w;
   logic [WIDTH-1:0] d_w;
   logic [CW-1:0]    cnt;

   logic [WIDTH:0]   r_sh;
   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   r_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic             no_borrow;
   logic             last_iter;
   logic             unused_r_msb;

   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;
   logic             dbz_q;

   // The restored partial remainder is always below the divisor, so its MSB stays 0.
   assign r_sh         = {r_w[WIDTH-1:0], q_w[WIDTH-1]};
   assign unused_r_msb = r_w[WIDTH];

   addsub_nbit #(.N(WIDTH + 1)) u_trial (
      .a      (r_sh),
      .b      ({1'b0, d_w}),
      .sel    (1'b1),
      .cout   (no_borrow),
      .result (trial)
   );

   assign r_nxt     = no_borrow ? trial : r_sh;
   assign q_nxt     = {q_w[WIDTH-2:0], no_borrow};
   assign last_iter = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (bus.start) state_nxt = (bus.divisor == '0) ? DONE : RUN;
         RUN:     if (last_iter) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_w         <= '0;
         q_w         <= '0;
         d_w         <= '0;
         cnt         <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  dbz_q <= 1'b0;
                  if (bus.divisor == '0) begin
                     quotient_q  <= '1;
                     remainder_q <= bus.dividend;
                     dbz_q       <= 1'b1;
                  end else begin
                     q_w <= bus.dividend;
                     r_w <= '0;
                     d_w <= bus.divisor;
                     cnt <= '0;
                  end
               end
            end
            RUN: begin
               r_w <= r_nxt;
               q_w <= q_nxt;
               cnt <= cnt + CW'(1);
               if (last_iter) begin
                  quotient_q  <= q_nxt;
                  remainder_q <= r_nxt[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy        = (state != IDLE);
   assign bus.done        = (state == DONE);
   assign bus.quotient    = quotient_q;
   assign bus.remainder   = remainder_q;
   assign bus.div_by_zero = dbz_q;

endmodule

// File: doc/div_restoring_4bit.md
Name: div_restoring_4bit

Overview:
Sequential restoring divider. It performs unsigned WIDTH-bit division by repeated trial subtraction, one quotient bit per clock. The trial-subtract datapath is a ripple add/sub built from our full-adder cells with sel tied to 1 (subtract). The block is the iterative counterpart to the combinational add/sub unit and serves as the arithmetic block's divide path.

Parameters:
WIDTH, 4, operand, quotient and remainder width in bits (legal range 2..16)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
dividend  input  WIDTH  unsigned dividend; sampled when start is accepted
divisor  input  WIDTH  unsigned divisor; sampled when start is accepted
busy  output  1  high whenever state is not IDLE
done  output  1  one-cycle pulse; results are valid from this cycle on
quotient  output  WIDTH  result quotient
remainder  output  WIDTH  result remainder
div_by_zero  output  1  flag for the last operation: divisor was 0

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, count=0.
- State machine: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - start=1 with divisor!=0: latch operands, set Q=dividend, R=0 (WIDTH+1 bits), D=divisor, count=0, go to RUN.
  - start=1 with divisor==0: go straight to DONE with quotient=all ones, remainder=dividend, div_by_zero=1.
  - Accepting any start clears div_by_zero. The zero case sets it again.
- RUN, one iteration per edge:
  - Form {R,Q} shifted left by 1.
  - Compute trial = R_shifted - {0,D}, WIDTH+1 bits, as R_shifted + ~{0,D} + 1.
  - Carry-out 1 (no borrow): R=trial, Q[0]=1.
  - Carry-out 0 (borrow): R=R_shifted (restore), Q[0]=0.
  - count increments each iteration. After WIDTH iterations go to DONE.
- DONE: lasts exactly one cycle.
  - done=1 for that cycle.
  - quotient=Q and remainder=R[WIDTH-1:0] are registered on entry to DONE.
  - Next state is IDLE.
- Output hold: quotient, remainder and div_by_zero hold their values until the next accepted start or a reset. They do not change during RUN. The working registers are separate from the output registers.
- Latency, measured from the edge that samples start:
  - Normal divide: done is high in the cycle after edge WIDTH+1 (WIDTH iterations plus the DONE entry; for WIDTH=4, done is visible after the 5th edge).
  - Divide by zero: done is visible after the 1st edge.
- start while busy=1 (RUN or DONE) is ignored. It is not queued.
- start held high continuously: a new operation begins on the first IDLE cycle after each DONE, so one operation completes every WIDTH+2 cycles.
- Operand changes after acceptance have no effect.
- Reset mid-operation: the current operation is abandoned immediately and all outputs take their reset values. No done pulse is emitted.
- Invariant, checked on every done with div_by_zero=0: dividend == quotient*divisor + remainder, and remainder < divisor.

Decomposition:
- Shared package div_pkg:
  - state enum: IDLE, RUN, DONE
  - constant CNT_W = $clog2(WIDTH+1)
  - WIDTH default
- One sub-module, addsub_nbit: parameterised (N=WIDTH+1) ripple add/sub built from full_adder.
  - Ports: a, b, sel, carry-out, result. sel=1 means subtract.
  - Carry-out=1 means no borrow.
  - Instantiated once with sel tied to 1.
- FSM, counter and shift registers stay in the top module.

Test Plan:
- Normal divide: reset release, then start with 13/3 -> done after 5 edges; quotient=4, remainder=1, div_by_zero=0; busy high from edge 1 until done falls.
- Edge operand values: 15/1 -> q=15, r=0. 7/9 -> q=0, r=7. 15/15 -> q=1, r=0. 0/5 -> q=0, r=0.
- Divide by zero: 9/0 -> done after 1 edge; q=15, r=9, div_by_zero=1. A following 8/2 clears the flag: q=4, r=0.
- Start while busy: start 12/5, then pulse start with 3/1 two cycles later -> ignored; result q=2, r=2. Outputs keep the previous values until done.
- Reset mid-operation: drop rst_n for one cycle at iteration 2 of 14/3 -> outputs read 0 and no done pulse; a new 14/3 then gives q=4, r=2.
- Exhaustive: all 256 operand pairs back-to-back with start held high -> invariant and div_by_zero hold on every done; one done every 6 cycles (every 2 cycles for divisor 0).
